// File: rtl/pio_fifo_pair.sv
// Paired TX/RX FIFOs between the host bus and one PIO machine, optional join doubles one side's depth.
// Latency: a word written at edge N is at the FWFT head after edge N; a pop advances the head at the next edge.
// Backpressure: full/empty come from registered levels; writes when full and pops when empty are dropped. Debug flags: PIO_FIFO_DEBUG_EN.

// Circular-buffer pointer and level control with a run-time capacity (0 disables the FIFO).
// Latency: pointers and level update on the edge that accepts a push or pop; flush zeroes them.
// Backpressure: push accepted when not full, or when full with a simultaneous pop.
module pio_fifo_ctrl #(
    parameter int LW = 4,
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [LW-1:0] cap,
    input  logic          push,
    input  logic          pop,
    output logic          push_ok,
    output logic          pop_ok,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] rd_nxt;

    // >= rather than == keeps the side blocked while a shrunk capacity waits for its flush
    assign empty   = (level == '0);
    assign full    = (level >= cap);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign wr_nxt = ((LW'(wr_ptr) + LW'(1)) >= cap) ? '0 : wr_ptr + PW'(1);
    assign rd_nxt = ((LW'(rd_ptr) + LW'(1)) >= cap) ? '0 : rd_ptr + PW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_nxt;
            if (pop_ok)  rd_ptr <= rd_nxt;
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end
endmodule

module pio_fifo_pair #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(2*DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             join_tx,
    input  logic             join_rx,
    input  logic             tx_write,
    input  logic [WIDTH-1:0] tx_wdata,
    output logic             tx_full,
    output logic [LW-1:0]    tx_level,
    input  logic             rx_read,
    output logic [WIDTH-1:0] rx_rdata,
    output logic             rx_empty,
    output logic [LW-1:0]    rx_level,
    input  logic             pull,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
`ifdef PIO_FIFO_DEBUG_EN
    input  logic [3:0]       dbg_clr,
    output logic [3:0]       dbg,
`endif
    output logic             full
);
    localparam int PW = $clog2(2*DEPTH);

    logic [WIDTH-1:0] mem [2*DEPTH];
    logic [1:0]       join_q;
    logic             join_chg;
    logic             rx_joined;
    logic [LW-1:0]    tx_cap;
    logic [LW-1:0]    rx_cap;
    logic [PW-1:0]    rx_base;
    logic [PW-1:0]    tx_wr;
    logic [PW-1:0]    tx_rd;
    logic [PW-1:0]    rx_wr;
    logic [PW-1:0]    rx_rd;
    logic             tx_push_ok;
    logic             tx_pop_ok;
    logic             rx_push_ok;
    logic             rx_pop_ok;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] rx_rdata_q;

    // join_rx only counts when TX has not already claimed the shared storage
    assign rx_joined = join_rx & ~join_tx;
    assign join_chg  = ({join_tx, join_rx} != join_q);
    assign tx_cap    = join_tx ? LW'(2*DEPTH) : (rx_joined ? '0 : LW'(DEPTH));
    assign rx_cap    = join_tx ? '0 : (rx_joined ? LW'(2*DEPTH) : LW'(DEPTH));
    assign rx_base   = rx_joined ? '0 : PW'(DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) join_q <= '0;
        else        join_q <= {join_tx, join_rx};
    end

    pio_fifo_ctrl #(.LW(LW), .PW(PW)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .flush   (join_chg),
        .cap     (tx_cap),
        .push    (tx_write & ~join_chg),
        .pop     (pull & ~join_chg),
        .push_ok (tx_push_ok),
        .pop_ok  (tx_pop_ok),
        .wr_ptr  (tx_wr),
        .rd_ptr  (tx_rd),
        .level   (tx_level),
        .full    (tx_full),
        .empty   (empty)
    );

    pio_fifo_ctrl #(.LW(LW), .PW(PW)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .flush   (join_chg),
        .cap     (rx_cap),
        .push    (push & ~join_chg),
        .pop     (rx_read & ~join_chg),
        .push_ok (rx_push_ok),
        .pop_ok  (rx_pop_ok),
        .wr_ptr  (rx_wr),
        .rd_ptr  (rx_rd),
        .level   (rx_level),
        .full    (full),
        .empty   (rx_empty)
    );

    // TX owns the low half, RX the high half; a joined side spans both halves
    always_ff @(posedge clk) begin
        if (tx_push_ok) mem[tx_wr] <= tx_wdata;
        if (rx_push_ok) mem[rx_base + rx_wr] <= din;
    end

    assign dout     = empty    ? dout_q     : mem[tx_rd];
    assign rx_rdata = rx_empty ? rx_rdata_q : mem[rx_base + rx_rd];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q     <= '0;
            rx_rdata_q <= '0;
        end else begin
            dout_q     <= dout;
            rx_rdata_q <= rx_rdata;
        end
    end

`ifdef PIO_FIFO_DEBUG_EN
    // Sticky {txover, rxunder, txstall, rxstall}; a new event beats a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dbg <= '0;
        else        dbg <= (dbg & ~dbg_clr) |
                           {tx_write & tx_full, rx_read & rx_empty, pull & empty, push & full};
    end
`else
    // No debug flag state in this build.
`endif

    logic unused_ok;
    assign unused_ok = tx_pop_ok ^ rx_pop_ok;
endmodule

// File: tb/tb_pio_fifo_pair.sv
module tb_pio_fifo_pair;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(2*DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             join_tx, join_rx;
    logic             tx_write;
    logic [WIDTH-1:0] tx_wdata;
    logic             tx_full;
    logic [LW-1:0]    tx_level;
    logic             rx_read;
    logic [WIDTH-1:0] rx_rdata;
    logic             rx_empty;
    logic [LW-1:0]    rx_level;
    logic             pull;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             push;
    logic [WIDTH-1:0] din;
    logic             full;
`ifdef PIO_FIFO_DEBUG_EN
    logic [3:0]       dbg_clr;
    logic [3:0]       dbg;
`endif

    int checks = 0;
    int errors = 0;

    pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .join_tx  (join_tx),
        .join_rx  (join_rx),
        .tx_write (tx_write),
        .tx_wdata (tx_wdata),
        .tx_full  (tx_full),
        .tx_level (tx_level),
        .rx_read  (rx_read),
        .rx_rdata (rx_rdata),
        .rx_empty (rx_empty),
        .rx_level (rx_level),
        .pull     (pull),
        .dout     (dout),
        .empty    (empty),
        .push     (push),
        .din      (din),
`ifdef PIO_FIFO_DEBUG_EN
        .dbg_clr  (dbg_clr),
        .dbg      (dbg),
`endif
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_tail [4];

    initial begin
        reset = 1'b1; join_tx = 0; join_rx = 0;
        tx_write = 0; tx_wdata = '0; rx_read = 0; pull = 0; push = 0; din = '0;
`ifdef PIO_FIFO_DEBUG_EN
        dbg_clr = '0;
`endif
        #1 reset = 1'b0;
        #20;
        chk("rst_tx_level", 32'(tx_level), 0);
        chk("rst_rx_level", 32'(rx_level), 0);
        chk("rst_empty",    32'(empty), 1);
        chk("rst_rx_empty", 32'(rx_empty), 1);
        chk("rst_tx_full",  32'(tx_full), 0);
        chk("rst_full",     32'(full), 0);
        chk("rst_dout",     dout, 0);
        chk("rst_rx_rdata", rx_rdata, 0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Fill TX, overflow, drain
        for (int i = 0; i < 4; i++) begin
            tx_write = 1; tx_wdata = 32'h11 * (i + 1);
            tick();
            if (i == 0) begin
                chk("first_wr_empty", 32'(empty), 0);
                chk("first_wr_dout",  dout, 32'h11);
            end
        end
        chk("fill_tx_full",  32'(tx_full), 1);
        chk("fill_tx_level", 32'(tx_level), 4);
        tx_wdata = 32'h55;
        tick();
        tx_write = 0;
        chk("ovf_tx_level", 32'(tx_level), 4);
        pull = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_dout", dout, 32'h11 * (i + 1));
            tick();
        end
        pull = 0;
        chk("drain_empty", 32'(empty), 1);
        chk("drain_hold",  dout, 32'h44);

        // Full with simultaneous write and pull
        for (int i = 0; i < 4; i++) begin
            tx_write = 1; tx_wdata = 32'h11 * (i + 1);
            tick();
        end
        tx_wdata = 32'h99; pull = 1;
        chk("fullrw_pulled", dout, 32'h11);
        tick();
        tx_write = 0;
        chk("fullrw_level", 32'(tx_level), 4);
        exp_tail[0] = 32'h22; exp_tail[1] = 32'h33; exp_tail[2] = 32'h44; exp_tail[3] = 32'h99;
        for (int i = 0; i < 4; i++) begin
            chk("fullrw_order", dout, exp_tail[i]);
            tick();
        end
        pull = 0;
        chk("fullrw_empty", 32'(empty), 1);

        // RX empty with simultaneous push and read
        push = 1; din = 32'hA5; rx_read = 1;
        tick();
        push = 0; rx_read = 0;
        chk("rxpr_level", 32'(rx_level), 1);
        chk("rxpr_rdata", rx_rdata, 32'hA5);
        chk("rxpr_empty", 32'(rx_empty), 0);
        rx_read = 1;
        tick();
        rx_read = 0;
        chk("rxpop_empty", 32'(rx_empty), 1);

        // Join TX with data present: flush, then 8-deep TX
        tx_write = 1; tx_wdata = 32'h01; tick();
        tx_wdata = 32'h02; tick();
        tx_write = 0;
        push = 1; din = 32'h77; tick();
        push = 0;
        chk("prejoin_tx_level", 32'(tx_level), 2);
        chk("prejoin_rx_level", 32'(rx_level), 1);
        join_tx = 1; tx_write = 1; tx_wdata = 32'hEE;
        tick();
        tx_write = 0;
        chk("join_flush_tx", 32'(tx_level), 0);
        chk("join_flush_rx", 32'(rx_level), 0);
        chk("join_full",     32'(full), 1);
        chk("join_rx_empty", 32'(rx_empty), 1);
        for (int i = 0; i < 8; i++) begin
            tx_write = 1; tx_wdata = 32'h100 + 32'(i);
            tick();
            chk("join_wr_tx_full", 32'(tx_full), (i == 7) ? 32'd1 : 32'd0);
            chk("join_wr_full",    32'(full), 1);
            chk("join_wr_rx_empty", 32'(rx_empty), 1);
        end
        tx_write = 0;
        chk("join_tx_level", 32'(tx_level), 8);
        push = 1; din = 32'h5; tick(); push = 0;
        chk("join_rx_ignored", 32'(rx_level), 0);
        pull = 1;
        for (int i = 0; i < 8; i++) begin
            chk("join_drain", dout, 32'h100 + 32'(i));
            tick();
        end
        pull = 0;
        chk("join_drain_empty", 32'(empty), 1);
        join_tx = 0; tick();
        chk("unjoin_full", 32'(full), 0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) begin
            push = 1; din = 32'h31 + 32'(i);
            tick();
        end
        chk("burst_rx_level", 32'(rx_level), 3);
        chk("burst_rx_rdata", rx_rdata, 32'h31);
        din = 32'h34;
        #2 reset = 1'b0;
        #1;
        chk("arst_rx_empty", 32'(rx_empty), 1);
        chk("arst_rx_level", 32'(rx_level), 0);
        push = 0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_arst_rx_empty", 32'(rx_empty), 1);

`ifdef PIO_FIFO_DEBUG_EN
        chk("dbg_rst", 32'(dbg), 0);
        pull = 1; tick(); pull = 0;
        chk("dbg_stall_set", 32'(dbg), 32'b0010);
        tick();
        chk("dbg_sticky", 32'(dbg), 32'b0010);
        dbg_clr = 4'b0010; tick(); dbg_clr = '0;
        chk("dbg_clr", 32'(dbg), 0);
        pull = 1; dbg_clr = 4'b0010; tick(); pull = 0; dbg_clr = '0;
        chk("dbg_set_wins", 32'(dbg), 32'b0010);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pio_fifo_pair.md
Name: pio_fifo_pair

Overview:
- Paired TX/RX FIFOs between the system bus and one PIO state machine.
- TX direction: the host writes words and the machine pulls them for OUT/PULL. RX direction: the machine pushes words from IN/PUSH and the host reads them.
- Machine-side signals connect directly to the machine's din/empty/pull and dout/full/push.
- Supports RP2040-style FIFO join: either direction borrows the other's storage for double depth.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 4, entries per direction when unjoined; power of two, at least 2.
- LW, $clog2(2*DEPTH)+1, level counter width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- join_tx  in  1  TX uses all 2*DEPTH entries; RX disabled.
- join_rx  in  1  RX uses all 2*DEPTH entries; TX disabled (ignored when join_tx=1).
- tx_write  in  1  host write strobe into TX.
- tx_wdata  in  WIDTH  host write data.
- tx_full  out  1  TX cannot accept a write.
- tx_level  out  LW  TX occupancy.
- rx_read  in  1  host read strobe from RX.
- rx_rdata  out  WIDTH  RX head word (first-word fall-through).
- rx_empty  out  1  RX holds no word.
- rx_level  out  LW  RX occupancy.
- pull  in  1  machine pops TX.
- dout  out  WIDTH  TX head word to the machine (FWFT).
- empty  out  1  TX empty, seen by the machine.
- push  in  1  machine pushes into RX.
- din  in  WIDTH  machine push data.
- full  out  1  RX full, seen by the machine.

Behaviour:
- Reset (async assert, sync deassert use) empties both FIFOs and clears pointers and levels:
  - tx_level=0, rx_level=0.
  - empty=1, rx_empty=1.
  - tx_full=0, full=0.
  - dout=0, rx_rdata=0.
  - Storage contents are not reset.
- Each FIFO is one circular buffer with read pointer, write pointer and level counter. Pointers wrap modulo its capacity.
- Capacity:
  - Unjoined: DEPTH per direction.
  - Joined direction: 2*DEPTH.
  - Disabled direction: 0.
- Disabled direction:
  - TX disabled: tx_full=1, empty=1.
  - RX disabled: full=1, rx_empty=1.
  - Strobes to a disabled direction are ignored.
- Flags are derived from the registered level only (no combinational path from strobes):
  - full = (level == capacity).
  - empty = (level == 0).
- Heads (FWFT):
  - dout and rx_rdata always show mem[rd_ptr] whenever the FIFO is non-empty, and hold the last value otherwise.
  - A pop advances the head on the next clk edge.
- Write latency: a word written at edge N is visible at the head and clears empty after edge N (one cycle). There is no same-cycle bypass.
- Push when full:
  - Dropped, no state change, unless a pop occurs in the same cycle.
  - Full with simultaneous pop and push: both accepted, level unchanged, pointers both advance.
- Pop when empty: ignored. Empty with simultaneous push and pop: push accepted, pop ignored, level becomes 1.
- Level arithmetic: level_next = level + push_ok - pop_ok. It never exceeds capacity and never underflows.
- Join changes:
  - Any change of join_tx or join_rx, detected by registering the join bits, flushes both FIFOs on the following edge (levels and pointers to 0).
  - Strobes in the cycle the change is detected are discarded.
- A reset assertion mid-transfer discards all stored data immediately.

Optional Feature:
- PIO_FIFO_DEBUG_EN.
- Defined: adds output dbg[3:0] = {txover, rxunder, txstall, rxstall} and input dbg_clr[3:0]. All four flags are sticky.
  - txover: host write while tx_full.
  - rxunder: host read while rx_empty.
  - txstall: pull while empty.
  - rxstall: push while full.
  - Each flag is cleared when its dbg_clr bit is 1; set wins over clear in the same cycle.
  - Flags reset to 0.
- Undefined: the ports are absent and no flag logic is synthesized.

Test Plan:
- Write 0x11,0x22,0x33,0x44 to TX (DEPTH=4) -> tx_full=1, tx_level=4. Fifth write 0x55 is dropped. Four pulls yield dout 0x11,0x22,0x33,0x44, then empty=1.
- TX full, same-cycle tx_write(0x99) and pull -> tx_level stays 4, pulled word 0x11, 0x99 is the last word out.
- RX empty, same-cycle push(0xA5) and rx_read -> rx_level=1, rx_rdata=0xA5 next cycle, rx_empty=0.
- Set join_tx=1 with TX holding 2 words -> both FIFOs flushed. Then 8 writes accepted, tx_full after the 8th, full=1 and rx_empty=1 throughout.
- Pull reset low mid-burst with 3 words in RX -> rx_empty=1, rx_level=0 immediately (asynchronous), before the next edge.
- With PIO_FIFO_DEBUG_EN, pull while empty -> dbg[1]=1 and stays set. dbg_clr=4'b0010 clears it the next edge.
